// File: rtl/repairval_pkg.sv
// repairval_pkg
//   Shared definitions for the MBINIT.REPAIRVAL sideband handshake.
//   Holds the 4-bit sideband message codes (common to the initiator and the
//   partner responder), the initiator state encoding and a helper that sizes
//   the WAIT/PATTERN timeout counter.
package repairval_pkg;

  // Sideband message codes exchanged with the partner block
  localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
  localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
  localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
  localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
  localparam logic [3:0] MSG_DONE_RESP   = 4'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK_BUSY_INIT,
    ST_SEND_INIT,
    ST_WAIT_INIT,
    ST_PATTERN,
    ST_CHK_BUSY_RESULT,
    ST_SEND_RESULT,
    ST_WAIT_RESULT,
    ST_CHK_BUSY_DONE,
    ST_SEND_DONE,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Bits needed to hold a count from 0 up to and including `cycles`
  function automatic int timeout_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/repairval_timeout_cnt.sv
// repairval_timeout_cnt
//   Cycle counter guarding the WAIT_* and PATTERN states of the REPAIRVAL
//   initiator. Counts while enabled, returns to zero on clear, and flags
//   expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
// Ports:
//   clk      in   block clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   return count to zero (state change)
//   enable   in   count this cycle (in a guarded state)
//   expired  out  terminal count reached while enabled
module repairval_timeout_cnt
  import repairval_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntW = timeout_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count;

  // Clear has priority so every new state starts its budget from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CntW'(1);
    end
  end

  assign expired = enable && (count == LastCount);

endmodule

// File: rtl/repairval_module_initiator.sv
// repairval_module_initiator
//   Initiator side of the MBINIT.REPAIRVAL sideband handshake:
//   init_req -> valid-lane pattern -> result_req -> done_req, each request
//   gated on sideband TX idle and each response wait guarded by a timeout.
//   All outputs are registered from the next state so they are valid in the
//   same cycle the state is entered.
// Build option:
//   REPAIRVAL_RETRY_EN  when defined, a failing partner result reruns the
//                       pattern up to MAX_RETRY times before closing.
// Ports:
//   CLK                            in   block clock
//   rst_n                          in   asynchronous active-low reset
//   i_REPAIRCLK_end                in   level enable; low aborts to IDLE
//   i_Rx_SbMessage[3:0]            in   decoded received sideband message
//   i_msg_valid                    in   qualifies i_Rx_SbMessage
//   i_VAL_Result_logged            in   msginfo of result_resp (1 = pass)
//   i_Busy_SideBand                in   sideband TX busy
//   i_falling_edge_busy            in   pulse: TX finished current message
//   i_valpattern_done              in   pulse: pattern generator finished
//   o_TX_SbMessage[3:0]            out  message code to send
//   o_ValidOutDatat_Module         out  TX request, high through SEND_*
//   o_valpattern_en                out  pattern generator enable
//   o_VAL_Result                   out  captured partner result
//   o_MBINIT_REPAIRVAL_Module_end  out  handshake complete
//   o_timeout                      out  timeout error, sticky until IDLE
module repairval_module_initiator
  import repairval_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_REPAIRCLK_end,
  input  logic [3:0] i_Rx_SbMessage,
  input  logic       i_msg_valid,
  input  logic       i_VAL_Result_logged,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_valpattern_done,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic       o_valpattern_en,
  output logic       o_VAL_Result,
  output logic       o_MBINIT_REPAIRVAL_Module_end,
  output logic       o_timeout
);

  state_t     state;
  state_t     next_state;
  logic [3:0] expected_resp;
  logic       in_send;
  logic       in_wait;
  logic       counting;
  logic       expired;
  logic       resp_now;
  logic       resp_seen;
  logic       result_val;
  logic       resp_pending;
  logic       pending_result;
  logic       capture;

  assign in_send  = state inside {ST_SEND_INIT, ST_SEND_RESULT, ST_SEND_DONE};
  assign in_wait  = state inside {ST_WAIT_INIT, ST_WAIT_RESULT, ST_WAIT_DONE};
  assign counting = in_wait || (state == ST_PATTERN);

  // Response each SEND/WAIT pair is looking for
  always_comb begin
    expected_resp = 4'd0;
    case (state)
      ST_SEND_INIT,   ST_WAIT_INIT:   expected_resp = MSG_INIT_RESP;
      ST_SEND_RESULT, ST_WAIT_RESULT: expected_resp = MSG_RESULT_RESP;
      ST_SEND_DONE,   ST_WAIT_DONE:   expected_resp = MSG_DONE_RESP;
      default:                        expected_resp = 4'd0;
    endcase
  end

  // A response latched during SEND counts as already received in WAIT
  assign resp_now   = i_msg_valid && (i_Rx_SbMessage == expected_resp) && (in_send || in_wait);
  assign resp_seen  = resp_now || resp_pending;
  assign result_val = resp_now ? i_VAL_Result_logged : pending_result;
  assign capture    = (state == ST_WAIT_RESULT) && resp_seen && (next_state != ST_IDLE);

`ifdef REPAIRVAL_RETRY_EN
  localparam int RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RetryW-1:0] retry_cnt;
  logic              retry_now;

  assign retry_now = !result_val && (retry_cnt < RetryW'(MAX_RETRY));

  // Number of pattern reruns already spent on failing results
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (next_state == ST_IDLE) begin
      retry_cnt <= '0;
    end else if ((state == ST_WAIT_RESULT) && (next_state == ST_PATTERN)) begin
      retry_cnt <= retry_cnt + RetryW'(1);
    end
  end
`else
  // MAX_RETRY only shapes the design when retries are compiled in
  if (MAX_RETRY < 0) begin : g_bad_max_retry
  end
`endif

  // Next-state logic; dropping the enable overrides every other transition
  always_comb begin
    next_state = state;
    if ((state != ST_IDLE) && !i_REPAIRCLK_end) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:            if (i_REPAIRCLK_end)     next_state = ST_CHK_BUSY_INIT;
        ST_CHK_BUSY_INIT:   if (!i_Busy_SideBand)    next_state = ST_SEND_INIT;
        ST_CHK_BUSY_RESULT: if (!i_Busy_SideBand)    next_state = ST_SEND_RESULT;
        ST_CHK_BUSY_DONE:   if (!i_Busy_SideBand)    next_state = ST_SEND_DONE;
        ST_SEND_INIT:       if (i_falling_edge_busy) next_state = ST_WAIT_INIT;
        ST_SEND_RESULT:     if (i_falling_edge_busy) next_state = ST_WAIT_RESULT;
        ST_SEND_DONE:       if (i_falling_edge_busy) next_state = ST_WAIT_DONE;
        ST_WAIT_INIT: begin
          if (resp_seen)    next_state = ST_PATTERN;
          else if (expired) next_state = ST_ERROR;
        end
        ST_PATTERN: begin
          if (i_valpattern_done) next_state = ST_CHK_BUSY_RESULT;
          else if (expired)      next_state = ST_ERROR;
        end
        ST_WAIT_RESULT: begin
          if (resp_seen) begin
`ifdef REPAIRVAL_RETRY_EN
            next_state = retry_now ? ST_PATTERN : ST_CHK_BUSY_DONE;
`else
            next_state = ST_CHK_BUSY_DONE;
`endif
          end else if (expired) begin
            next_state = ST_ERROR;
          end
        end
        ST_WAIT_DONE: begin
          if (resp_seen)    next_state = ST_DONE;
          else if (expired) next_state = ST_ERROR;
        end
        default: next_state = state;
      endcase
    end
  end

  // Early-response latch: set in SEND, consumed and cleared leaving WAIT
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      resp_pending   <= 1'b0;
      pending_result <= 1'b0;
    end else if ((next_state == ST_IDLE) || (in_wait && (next_state != state))) begin
      resp_pending   <= 1'b0;
      pending_result <= 1'b0;
    end else if (in_send && resp_now) begin
      resp_pending   <= 1'b1;
      pending_result <= i_VAL_Result_logged;
    end
  end

  // State register with outputs decoded from the state being entered
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state                         <= ST_IDLE;
      o_TX_SbMessage                <= 4'd0;
      o_ValidOutDatat_Module        <= 1'b0;
      o_valpattern_en               <= 1'b0;
      o_VAL_Result                  <= 1'b0;
      o_MBINIT_REPAIRVAL_Module_end <= 1'b0;
      o_timeout                     <= 1'b0;
    end else begin
      state <= next_state;
      case (next_state)
        ST_SEND_INIT:   o_TX_SbMessage <= MSG_INIT_REQ;
        ST_SEND_RESULT: o_TX_SbMessage <= MSG_RESULT_REQ;
        ST_SEND_DONE:   o_TX_SbMessage <= MSG_DONE_REQ;
        default:        o_TX_SbMessage <= 4'd0;
      endcase
      o_ValidOutDatat_Module        <= next_state inside {ST_SEND_INIT, ST_SEND_RESULT, ST_SEND_DONE};
      o_valpattern_en               <= (next_state == ST_PATTERN);
      o_MBINIT_REPAIRVAL_Module_end <= (next_state == ST_DONE);
      o_timeout                     <= (next_state == ST_ERROR);
      if (next_state == ST_IDLE) begin
        o_VAL_Result <= 1'b0;
      end else if (capture) begin
        o_VAL_Result <= result_val;
      end
    end
  end

  repairval_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (CLK),
    .rst_n  (rst_n),
    .clear  (next_state != state),
    .enable (counting),
    .expired(expired)
  );

endmodule

// File: tb/tb_repairval_module_initiator.sv
// tb_repairval_module_initiator
//   Directed bench for the REPAIRVAL initiator: nominal handshake, busy
//   gating, early response, abort/restart, timeout, exit-versus-expiry at
//   the terminal count, and (with REPAIRVAL_RETRY_EN) the retry loop.
module tb_repairval_module_initiator;

  logic       CLK;
  logic       rst_n;
  logic       en;
  logic [3:0] rx_msg;
  logic       msg_valid;
  logic       logged;
  logic       busy;
  logic       fe_busy;
  logic       vp_done;
  logic [3:0] tx_msg;
  logic       tx_valid;
  logic       vp_en;
  logic       val_result;
  logic       module_end;
  logic       timeout;
  logic [8:0] all_out;

  int total_checks  = 0;
  int passed_checks = 0;

  assign all_out = {tx_msg, tx_valid, vp_en, val_result, module_end, timeout};

  repairval_module_initiator #(
    .TIMEOUT_CYCLES(100),
    .MAX_RETRY     (2)
  ) dut (
    .CLK                          (CLK),
    .rst_n                        (rst_n),
    .i_REPAIRCLK_end              (en),
    .i_Rx_SbMessage               (rx_msg),
    .i_msg_valid                  (msg_valid),
    .i_VAL_Result_logged          (logged),
    .i_Busy_SideBand              (busy),
    .i_falling_edge_busy          (fe_busy),
    .i_valpattern_done            (vp_done),
    .o_TX_SbMessage               (tx_msg),
    .o_ValidOutDatat_Module       (tx_valid),
    .o_valpattern_en              (vp_en),
    .o_VAL_Result                 (val_result),
    .o_MBINIT_REPAIRVAL_Module_end(module_end),
    .o_timeout                    (timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    else
      passed_checks++;
  endtask

  // Present one received sideband message for a single cycle
  task automatic applyStimulus(input logic [3:0] code, input logic log_val);
    rx_msg    = code;
    msg_valid = 1'b1;
    logged    = log_val;
    tick();
    rx_msg    = 4'd0;
    msg_valid = 1'b0;
    logged    = 1'b0;
  endtask

  task automatic pulseFallingEdge();
    fe_busy = 1'b1;
    tick();
    fe_busy = 1'b0;
  endtask

  task automatic pulsePatternDone();
    vp_done = 1'b1;
    tick();
    vp_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ok;
    int pattern_entries;

    rst_n = 1'b0; en = 1'b0; rx_msg = 4'd0; msg_valid = 1'b0; logged = 1'b0;
    busy = 1'b0; fe_busy = 1'b0; vp_done = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_outputs", 32'(all_out), 0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_no_enable", 32'(all_out), 0);

    // Nominal handshake
    en = 1'b1;
    tick();
    checkOutput("chk_busy_init_quiet", 32'(tx_valid), 0);
    tick();
    checkOutput("send_init_code", 32'(tx_msg), 1);
    checkOutput("send_init_valid", 32'(tx_valid), 1);
    tick();
    checkOutput("send_init_held", 32'(tx_valid), 1);
    pulseFallingEdge();
    checkOutput("wait_init_valid_off", 32'(tx_valid), 0);
    applyStimulus(4'd4, 1'b0);
    checkOutput("wait_init_ignores_other", 32'(vp_en), 0);
    applyStimulus(4'd2, 1'b0);
    checkOutput("pattern_enabled", 32'(vp_en), 1);
    pulseFallingEdge();
    checkOutput("pattern_ignores_fe", 32'(vp_en), 1);
    ok = 1;
    repeat (62) begin
      tick();
      if (vp_en !== 1'b1) ok = 0;
    end
    checkOutput("pattern_held", 32'(ok), 1);
    pulsePatternDone();
    checkOutput("pattern_off_after_done", 32'(vp_en), 0);
    tick();
    checkOutput("send_result_code", 32'(tx_msg), 3);
    pulseFallingEdge();
    checkOutput("wait_result_valid_off", 32'(tx_valid), 0);
    applyStimulus(4'd4, 1'b1);
    checkOutput("result_captured", 32'(val_result), 1);
    tick();
    checkOutput("send_done_code", 32'(tx_msg), 5);
    pulseFallingEdge();
    applyStimulus(4'd6, 1'b0);
    checkOutput("done_end", 32'(module_end), 1);
    checkOutput("done_result_held", 32'(val_result), 1);
    repeat (3) tick();
    checkOutput("done_end_held", 32'(module_end), 1);
    en = 1'b0;
    tick();
    checkOutput("idle_after_done", 32'(all_out), 0);

    // Busy gating at CHK_BUSY_INIT
    busy = 1'b1;
    en   = 1'b1;
    ok   = 1;
    repeat (21) begin
      tick();
      if (tx_valid !== 1'b0) ok = 0;
    end
    checkOutput("busy_blocks_send", 32'(ok), 1);
    busy = 1'b0;
    tick();
    checkOutput("code_after_busy_drop", 32'(tx_msg), 1);
    checkOutput("valid_after_busy_drop", 32'(tx_valid), 1);

    // Early init_resp two cycles before the TX falling edge
    applyStimulus(4'd2, 1'b0);
    checkOutput("early_resp_stays_send", 32'(tx_valid), 1);
    tick();
    pulseFallingEdge();
    checkOutput("early_wait_init", 32'(tx_valid), 0);
    tick();
    checkOutput("early_resp_pattern", 32'(vp_en), 1);

    // Abort mid-PATTERN and restart
    repeat (5) tick();
    en = 1'b0;
    tick();
    checkOutput("abort_all_zero", 32'(all_out), 0);
    en = 1'b1;
    tick();
    tick();
    checkOutput("restart_code", 32'(tx_msg), 1);

    // Timeout with no init_resp
    pulseFallingEdge();
    ok = 1;
    repeat (99) begin
      tick();
      if (timeout !== 1'b0) ok = 0;
    end
    checkOutput("no_early_timeout", 32'(ok), 1);
    tick();
    checkOutput("timeout_at_100", 32'(timeout), 1);
    checkOutput("timeout_no_end", 32'(module_end), 0);
    repeat (5) tick();
    checkOutput("timeout_sticky", 32'(timeout), 1);
    en = 1'b0;
    tick();
    checkOutput("timeout_cleared", 32'(all_out), 0);

    // Pattern done on the terminal-count cycle: exit beats expiry
    en = 1'b1;
    tick();
    tick();
    pulseFallingEdge();
    applyStimulus(4'd2, 1'b0);
    repeat (99) tick();
    pulsePatternDone();
    checkOutput("exit_wins_pattern_off", 32'(vp_en), 0);
    checkOutput("exit_wins_no_timeout", 32'(timeout), 0);
    tick();
    checkOutput("exit_wins_send_result", 32'(tx_msg), 3);
    en = 1'b0;
    tick();

`ifdef REPAIRVAL_RETRY_EN
    // Three failing results with MAX_RETRY = 2
    en = 1'b1;
    tick();
    tick();
    pulseFallingEdge();
    applyStimulus(4'd2, 1'b0);
    pattern_entries = (vp_en === 1'b1) ? 1 : 0;
    for (int r = 0; r < 3; r++) begin
      repeat (3) tick();
      pulsePatternDone();
      tick();
      pulseFallingEdge();
      applyStimulus(4'd4, 1'b0);
      if (vp_en === 1'b1) pattern_entries++;
    end
    checkOutput("retry_pattern_entries", 32'(pattern_entries), 3);
    tick();
    checkOutput("retry_send_done_code", 32'(tx_msg), 5);
    checkOutput("retry_result_zero", 32'(val_result), 0);
    pulseFallingEdge();
    applyStimulus(4'd6, 1'b0);
    checkOutput("retry_end", 32'(module_end), 1);
    en = 1'b0;
    tick();
`else
    pattern_entries = 0;
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
